// File: rtl/timer_counter_param.sv
// WIDTH-bit up/down timer with a power-of-two prescaler, optional auto-reload,
// compare match and sticky overflow/underflow/match flags.
module timer_counter_param #(
   parameter int WIDTH = 8,
   parameter int PSC_W = 7,
   parameter int SEL_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic [SEL_W-1:0] i_psc_sel,
   input  logic             i_up_down,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_start_counter,
   input  logic             i_auto_reload,
   input  logic [WIDTH-1:0] i_compare,
   input  logic             i_clr_overflow,
   input  logic             i_clr_underflow,
   input  logic             i_clr_match,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tick,
   output logic             o_overflow,
   output logic             o_underflow,
   output logic             o_match
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(PSC_W);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic [PSC_W-1:0] r_psc;
   logic             r_tick;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_match;

   logic [SEL_W-1:0] w_sel;
   logic [PSC_W-1:0] w_mask;
   logic             w_tick_next;
   logic             w_step;
   logic [WIDTH-1:0] w_cnt_step;
   logic             w_ovf_wrap;
   logic             w_unf_wrap;
   logic             w_ovf_set;
   logic             w_unf_set;
   logic             w_match_set;

   assign w_sel = (i_psc_sel > SEL_MAX) ? SEL_MAX : i_psc_sel;

   // mask = 2^n - 1 built bitwise so n = PSC_W needs no wider intermediate
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PSC_W; i++) begin
         w_mask[i] = (SEL_W'(i) < w_sel);
      end
   end

   assign w_tick_next = i_enable & ~i_load & ((r_psc & w_mask) == w_mask);
   assign w_step      = r_tick & i_enable & ~i_load;

   always_comb begin
      w_cnt_step = r_count;
      w_ovf_wrap = 1'b0;
      w_unf_wrap = 1'b0;
      if (i_up_down) begin
         if (r_count == CNT_MAX) begin
            w_cnt_step = i_auto_reload ? r_reload : '0;
            w_ovf_wrap = 1'b1;
         end else begin
            w_cnt_step = r_count + WIDTH'(1);
         end
      end else begin
         if (r_count == '0) begin
            w_cnt_step = i_auto_reload ? r_reload : CNT_MAX;
            w_unf_wrap = 1'b1;
         end else begin
            w_cnt_step = r_count - WIDTH'(1);
         end
      end
   end

   assign w_ovf_set   = w_step & w_ovf_wrap;
   assign w_unf_set   = w_step & w_unf_wrap;
   assign w_match_set = w_step & (w_cnt_step == i_compare);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count     <= '0;
         r_reload    <= '0;
         r_psc       <= '0;
         r_tick      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_match     <= 1'b0;
      end else begin
         r_tick <= w_tick_next;
         if (i_load) begin
            r_count  <= i_start_counter;
            r_reload <= i_start_counter;
            r_psc    <= '0;
         end else begin
            if (i_enable) begin
               r_psc <= r_psc + PSC_W'(1);
            end
            if (w_step) begin
               r_count <= w_cnt_step;
            end
         end
         // set beats a same-edge clear
         r_overflow  <= w_ovf_set   | (r_overflow  & ~i_clr_overflow);
         r_underflow <= w_unf_set   | (r_underflow & ~i_clr_underflow);
         r_match     <= w_match_set | (r_match     & ~i_clr_match);
      end
   end

   assign o_count     = r_count;
   assign o_tick      = r_tick;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
   assign o_match     = r_match;

endmodule

// File: doc/timer_counter_param.md
# timer_counter_param

Parametrised successor of the 8-bit timer counter: a WIDTH-bit up/down counter with a built-in programmable prescaler, optional auto-reload, a compare-match flag and three sticky status flags. It sits in the timer subsystem between the register interface, which drives the control inputs and clear strobes, and the interrupt logic, which consumes the flags. The external clock-enable input of the earlier generation is replaced by an internal power-of-two prescaler, so the counter pace is selected at run time.

## Interface
- WIDTH, 8, counter and compare width (≥2)
- PSC_W, 7, prescaler counter width; divide ratios 2^0 … 2^PSC_W
- SEL_W, 3, width of psc_sel; must satisfy 2^SEL_W ≥ PSC_W+1
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = prescaler and counter run; 0 = both hold
- psc_sel  in  SEL_W  divide select n: one tick every 2^n enabled cycles; values > PSC_W are clamped to PSC_W
- up_down  in  1  1 = count up, 0 = count down; sampled at each tick
- load  in  1  load strobe
- start_counter  in  WIDTH  load value; also captured as the reload value
- auto_reload  in  1  1 = wrap to the reload value; 0 = wrap to 0 (up) or max (down)
- compare  in  WIDTH  compare value
- clr_overflow / clr_underflow / clr_match  in  1 each  flag clear strobes
- count  out  WIDTH  current counter value (reg_TCNT)
- tick  out  1  registered prescaler pulse; the counter steps on the edge that ends a tick=1 cycle
- overflow / underflow / match  out  1 each  sticky flags

## Operation
- Reset: count=0, reload_val=0, prescaler=0, tick=0, and all flags=0. Reset overrides every other input.
- Prescaler: a PSC_W-bit counter increments each cycle while enable=1 and load=0, and holds while enable=0.
  - mask = 2^n − 1, where n is the clamped psc_sel.
  - tick_next = enable & ~load & ((psc & mask) == mask).
  - With n=0, tick is 1 on every enabled cycle.
- Load (highest priority after reset), on the edge where load=1:
  - count←start_counter, reload_val←start_counter, prescaler←0, tick←0.
  - Load works regardless of enable.
  - No flag is set by the load itself.
- Step: on an edge with tick=1, load=0 and enable=1, the counter steps in the direction given by up_down at that edge.
  - Up, count<max: count+1.
  - Up, count=max: count←(auto_reload ? reload_val : 0) and overflow is set.
  - Down, count>0: count−1.
  - Down, count=0: count←(auto_reload ? reload_val : max) and underflow is set.
  - A direction change between ticks, including before the first tick after a load, takes effect at the next tick with no penalty.
- Match: set on the step edge where the new count equals compare. Loading a value equal to compare does not set match.
- Flags are sticky until their clr_* strobe. When set and clear occur on the same edge, set wins.
- Arithmetic is unsigned modulo 2^WIDTH. max = 2^WIDTH − 1.

## Timing
- Latency from load to count update: 1 edge.
- First tick after a load: at n=0, tick=1 in the cycle after the load edge, so the first step happens 2 edges after load. In general, the first step happens 2^n + 1 edges after the load edge.
- Flags assert on the same edge that writes the wrap or match value to count, and are visible 1 cycle after the tick=1 cycle.
- clr_* to flag low: 1 edge.
- enable=0 while tick=1: tick is ignored and cleared. Prescaler phase is preserved for resume.
- load during tick=1: load wins, with no step and no flag.
- Reset asserted mid-count: all state returns to reset values on that edge, and flags are lost.
- psc_sel changed mid-count: the new mask applies to the current prescaler value from the next cycle, with no resync.

## Test plan
- Up/down switch before first tick (WIDTH=8, n=0): load 10 with up_down=1, then up_down=0 on the next cycle → count steps 10→9→…→0. On the 11th step, count=255, underflow=1, overflow=0. No flag is set before that edge.
- Overflow with auto-reload: load 250, auto_reload=1, up, n=0 → after 5 steps count=255; 6th step count=250 and overflow=1. Overflow stays 1 until clr_overflow, then clears 1 edge later.
- Prescaler: load 0, up, psc_sel=2 → tick is high exactly every 4th enabled cycle. count=3 at 13 edges after load. Toggling enable low for 5 cycles delays all steps by exactly 5.
- Compare match: compare=7, load 5, up → match=1 on the edge count becomes 7. Simultaneous clr_match on a later match edge leaves match=1.
- Priority and reset: assert load=1 on a tick=1 cycle → count=start_counter with no step. Assert rst mid-count at count=0x42 with underflow=1 → next cycle count=0 and all flags=0.
- WIDTH=12, PSC_W=7 instance: load 0, down, n=0 → first step gives count=4095 and underflow=1. psc_sel=7 yields one tick per 128 cycles.
